prm_load_ctrl: RTL and testbench
================================

PRM_LOAD_CTRL -- requirements
Module: prm_load_ctrl

Interface
REQ-001 SHALL have parameter F_NUM, default 16, number of cores; must be a multiple of 4.
REQ-002 SHALL have parameter NBANK, default F_NUM/4, number of 4-core write banks.
REQ-003 AXIS_ACLK  in  1  sole clock; all state is updated on its rising edge.
REQ-004 AXIS_ARESETN  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse; starts a parameter load; honoured only in IDLE.
REQ-006 abort  in  1  level; synchronous return to IDLE (driven from ~run).
REQ-007 bwrite  in  1  sampled at start: 1 = bias load (one beat per bank), 0 = weight load.
REQ-008 ks  in  10  sampled at start: words per bank minus 1 for weight load.
REQ-009 hold  in  1  level; deasserts src_ready while high (back-pressure).
REQ-010 src_valid, src_last  in  1 each  AXI-Stream slave valid and last.
REQ-011 src_ready  out  1  AXI-Stream slave ready.
REQ-012 prm_v  out  4  bank select for the current beat.
REQ-013 prm_a  out  10  word address for the current beat.
REQ-014 prm_we  out  1  write strobe to the cores: src_valid & src_ready.
REQ-015 busy, done, err  out  1 each  load active; one-cycle completion pulse; sticky framing error.

Function
REQ-016 SHALL implement the states IDLE, LOAD and DONE.
REQ-017 In IDLE, start SHALL capture bwrite and ks, clear prm_v, prm_a and err, and move to LOAD.
REQ-018 In LOAD, src_ready SHALL equal ~hold & ~abort and SHALL be 0 in every other state.
REQ-019 A beat is accepted only on src_valid & src_ready; prm_v and prm_a SHALL hold while no beat is accepted.
REQ-020 In weight mode, each accepted beat SHALL increment prm_a; at prm_a == ks it SHALL wrap to 0 and prm_v SHALL increment.
REQ-021 In bias mode, prm_a SHALL stay 0 and prm_v SHALL increment on every accepted beat.
REQ-022 The final beat is the one accepted at prm_v == NBANK-1 and prm_a == (bwrite ? 0 : ks); accepting it SHALL move the state to DONE.
REQ-023 src_last high on a non-final beat SHALL set err, write that beat, and move to DONE (early termination).
REQ-024 src_last low on the final beat SHALL set err; the load SHALL still complete normally.
REQ-025 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-026 busy SHALL be 1 in LOAD and DONE.
REQ-027 start SHALL be ignored outside IDLE; start and abort high together SHALL leave the block in IDLE.
REQ-028 abort in LOAD SHALL return to IDLE next cycle, drop src_ready in the same cycle combinationally, not pulse done, and preserve err.
REQ-029 ks = 0 SHALL give one beat per bank, behaving as bias mode with respect to the count.
REQ-030 There SHALL be no extra latency: prm_v and prm_a are valid in the same cycle as the beat they address.

Reset
REQ-031 AXIS_ARESETN low SHALL asynchronously force IDLE, with prm_v = 0, prm_a = 0, err = 0, done = 0, busy = 0 and src_ready = 0.
REQ-032 Reset released mid-load SHALL leave the block in IDLE; no partial state SHALL survive.

Structure
REQ-033 The state encoding and the bank-count width SHALL live in the shared tiny_dnn package, alongside f_num.
REQ-034 The design SHALL be a single module with no sub-modules; the address/bank counter is inline.

Verification
REQ-035 Weight load, ks = 3, 16 beats, last on beat 16 -> prm_v/prm_a step 0/0..0/3, 1/0..3/3; done pulses 1 cycle after beat 16; err = 0.
REQ-036 Bias load, 4 beats -> prm_a = 0 throughout; prm_v = 0, 1, 2, 3; done after beat 4.
REQ-037 ks = 3, hold toggled every other cycle and src_valid randomly gapped -> prm_we count = 16; addresses match REQ-035.
REQ-038 ks = 3, src_last on beat 6 -> beat 6 written at bank 1 address 1; err = 1; done pulses; IDLE next.
REQ-039 Abort after beat 5 -> src_ready = 0 in the abort cycle; IDLE next; no done pulse; a new start reloads from 0/0.
REQ-040 AXIS_ARESETN asserted mid-load -> all outputs 0 immediately; start after release behaves as REQ-035.

Source files
------------

// File: rtl/prm_load_ctrl_pkg.sv
// Shared constants and types for the parameter-load controller.
package prm_load_ctrl_pkg;

  // Default core count; the controller writes cores in banks of four.
  localparam int unsigned f_num = 16;

  // Widths of the bank select and of the per-bank word address.
  localparam int unsigned BANK_W = 4;
  localparam int unsigned KS_W   = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/prm_load_ctrl_if.sv
// AXI-Stream style source channel feeding the parameter loader.
interface prm_load_ctrl_if;
  logic src_valid;
  logic src_last;
  logic src_ready;

  modport master (
    output src_valid,
    output src_last,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_last,
    output src_ready
  );
endinterface

// File: rtl/prm_load_ctrl.sv
// Parameter-load controller: steers an incoming stream of weight or bias words
// onto per-bank core write ports, tracking bank/address and framing errors.
module prm_load_ctrl
  import prm_load_ctrl_pkg::*;
#(
  parameter int unsigned F_NUM = f_num,
  parameter int unsigned NBANK = F_NUM / 4
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic              bwrite,
  input  logic [KS_W-1:0]   ks,
  input  logic              hold,
  prm_load_ctrl_if.slave    src,
  output logic [BANK_W-1:0] prm_v,
  output logic [KS_W-1:0]   prm_a,
  output logic              prm_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic                bw_q, bw_d;
  logic [KS_W-1:0]     ks_q, ks_d;
  logic [BANK_W-1:0]   prm_v_q, prm_v_d;
  logic [KS_W-1:0]     prm_a_q, prm_a_d;
  logic                err_q, err_d;

  logic                src_ready;
  logic                beat;
  logic                final_beat;
  logic [KS_W-1:0]     last_addr;

  // State, captured load mode and bank/address counter.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q <= StIdle;
      bw_q    <= 1'b0;
      ks_q    <= '0;
      prm_v_q <= '0;
      prm_a_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bw_q    <= bw_d;
      ks_q    <= ks_d;
      prm_v_q <= prm_v_d;
      prm_a_q <= prm_a_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter advance and handshake decode.
  always_comb begin
    state_d   = state_q;
    bw_d      = bw_q;
    ks_d      = ks_q;
    prm_v_d   = prm_v_q;
    prm_a_d   = prm_a_q;
    err_d     = err_q;
    src_ready = 1'b0;
    beat      = 1'b0;

    // Bias loads (and ks == 0) carry one word per bank, so the last word is address 0.
    last_addr  = bw_q ? '0 : ks_q;
    final_beat = (prm_v_q == BANK_W'(NBANK - 1)) && (prm_a_q == last_addr);

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StLoad;
          bw_d    = bwrite;
          ks_d    = ks;
          prm_v_d = '0;
          prm_a_d = '0;
          err_d   = 1'b0;
        end
      end

      StLoad: begin
        src_ready = ~hold & ~abort;
        beat      = src.src_valid & src_ready;
        if (abort) begin
          state_d = StIdle;
        end else if (beat) begin
          if (final_beat) begin
            state_d = StDone;
            if (!src.src_last) err_d = 1'b1;
          end else if (src.src_last) begin
            // Early termination: the beat is still written, the load ends here.
            state_d = StDone;
            err_d   = 1'b1;
          end else if (bw_q || (prm_a_q == ks_q)) begin
            prm_a_d = '0;
            prm_v_d = prm_v_q + 1'b1;
          end else begin
            prm_a_d = prm_a_q + 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign src.src_ready = src_ready;
  assign prm_we        = beat;
  assign prm_v         = prm_v_q;
  assign prm_a         = prm_a_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign err           = err_q;

endmodule

// File: tb/tb_prm_load_ctrl.sv
// Self-checking bench for prm_load_ctrl: a beat-indexed model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_prm_load_ctrl;

  localparam int NBANK = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       bwrite;
  logic [9:0] ks;
  logic       hold;
  logic [3:0] prm_v;
  logic [9:0] prm_a;
  logic       prm_we;
  logic       busy;
  logic       done;
  logic       err;

  prm_load_ctrl_if sif ();

  prm_load_ctrl #(
    .F_NUM (16),
    .NBANK (NBANK)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .start        (start),
    .abort        (abort),
    .bwrite       (bwrite),
    .ks           (ks),
    .hold         (hold),
    .src          (sif),
    .prm_v        (prm_v),
    .prm_a        (prm_a),
    .prm_we       (prm_we),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 done; m_beat is the 0-based index of the
  // beat currently addressed within the load.
  int m_phase = 0;
  int m_beat  = 0;
  int m_total = 0;
  int m_ks    = 0;
  bit m_bw    = 0;
  bit m_err   = 0;

  // Expected bank/address of beat k, packed as v*1024 + a.
  function automatic int addr_of(input int k);
    if (m_bw) return k * 1024;
    return (k / (m_ks + 1)) * 1024 + (k % (m_ks + 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_err   <= 0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
          m_phase <= 1;
          m_beat  <= 0;
          m_err   <= 0;
          m_bw    <= bwrite;
          m_ks    <= int'(ks);
          m_total <= bwrite ? NBANK : NBANK * (int'(ks) + 1);
        end
        1: if (abort) begin
          m_phase <= 0;
        end else if (sif.src_valid && !hold) begin
          if (m_beat == m_total - 1) begin
            m_phase <= 2;
            if (!sif.src_last) m_err <= 1;
          end else if (sif.src_last) begin
            m_phase <= 2;
            m_err   <= 1;
          end else begin
            m_beat <= m_beat + 1;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  int acc_log[$];
  int done_cnt = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = rst_n && (m_phase == 1) && !hold && !abort;
    chk("src_ready", int'(sif.src_ready), int'(exp_ready));
    chk("prm_we", int'(prm_we), int'(exp_ready && sif.src_valid));
    chk("busy", int'(busy), int'(rst_n && m_phase != 0));
    chk("done", int'(done), int'(rst_n && m_phase == 2));
    chk("err", int'(err), int'(m_err));
    if (!rst_n) chk("va_reset", int'(prm_v) * 1024 + int'(prm_a), 0);
    else if (m_phase != 0) chk("prm_va", int'(prm_v) * 1024 + int'(prm_a), addr_of(m_beat));
    if (prm_we) acc_log.push_back(int'(prm_v) * 1024 + int'(prm_a));
    if (done) done_cnt++;
  end

  task automatic do_start(input bit bw, input int k);
    start  = 1'b1;
    bwrite = bw;
    ks     = 10'(k);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Drives up to n beats; beat number last_beat (1-based) carries src_last and
  // ends the stream. abort_after >= 0 raises abort once that many beats are in.
  task automatic stream(input int n, input int last_beat, input bit gaps, input bit hold_tog,
                        input int abort_after);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    while (sent < n && !(last_beat > 0 && sent >= last_beat) && cyc < 400) begin
      if (abort_after >= 0 && sent == abort_after) begin
        abort         = 1'b1;
        sif.src_valid = 1'b1;
        hold          = 1'b0;
        @(negedge clk);
        chk("abort_ready_drop", int'(sif.src_ready), 0);
        @(posedge clk); #1;
        abort         = 1'b0;
        sif.src_valid = 1'b0;
        chk("abort_idle", int'(busy), 0);
        return;
      end
      sif.src_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      hold          = hold_tog ? cyc[0] : 1'b0;
      sif.src_last  = (sent + 1 == last_beat);
      @(negedge clk);
      acc = sif.src_valid && sif.src_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    sif.src_valid = 1'b0;
    sif.src_last  = 1'b0;
    hold          = 1'b0;
    if (cyc >= 400) chk("stream_timeout", cyc, 0);
  endtask

  task automatic full_weight_ks3();
    int d0;
    acc_log.delete();
    d0 = done_cnt;
    do_start(1'b0, 3);
    stream(16, 16, 1'b0, 1'b0, -1);
    chk("w_done_now", int'(done), 1);
    @(posedge clk); #1;
    chk("w_beats", acc_log.size(), 16);
    if (acc_log.size() >= 16) begin
      chk("w_beat1", acc_log[0], 0);
      chk("w_beat5", acc_log[4], 1 * 1024 + 0);
      chk("w_beat16", acc_log[15], 3 * 1024 + 3);
    end
    chk("w_err", int'(err), 0);
    chk("w_done_pulses", done_cnt - d0, 1);
    chk("w_idle", int'(busy), 0);
  endtask

  initial begin
    int d0;
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    bwrite        = 1'b0;
    ks            = '0;
    hold          = 1'b0;
    sif.src_valid = 1'b0;
    sif.src_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(sif.src_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_va", int'(prm_v) * 1024 + int'(prm_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Weight load, ks = 3.
    full_weight_ks3();

    // Bias load: one beat per bank.
    acc_log.delete();
    do_start(1'b1, 7);
    stream(4, 4, 1'b0, 1'b0, -1);
    @(posedge clk); #1;
    chk("b_beats", acc_log.size(), 4);
    if (acc_log.size() >= 4) begin
      chk("b_beat2", acc_log[1], 1 * 1024);
      chk("b_beat4", acc_log[3], 3 * 1024);
    end

    // Back-pressure and gapped valid; a start during the load is ignored.
    acc_log.delete();
    do_start(1'b0, 3);
    start  = 1'b1;
    bwrite = 1'b1;
    ks     = 10'd0;
    @(posedge clk); #1;
    start  = 1'b0;
    stream(16, 16, 1'b1, 1'b1, -1);
    @(posedge clk); #1;
    chk("g_beats", acc_log.size(), 16);
    if (acc_log.size() >= 16) chk("g_beat16", acc_log[15], 3 * 1024 + 3);
    chk("g_err", int'(err), 0);

    // Early src_last on beat 6.
    acc_log.delete();
    d0 = done_cnt;
    do_start(1'b0, 3);
    stream(16, 6, 1'b0, 1'b0, -1);
    chk("e_done_now", int'(done), 1);
    @(posedge clk); #1;
    chk("e_beats", acc_log.size(), 6);
    if (acc_log.size() >= 6) chk("e_beat6", acc_log[5], 1 * 1024 + 1);
    chk("e_err", int'(err), 1);
    chk("e_done_pulses", done_cnt - d0, 1);
    chk("e_idle", int'(busy), 0);

    // Missing src_last on the final beat: error, normal completion.
    acc_log.delete();
    do_start(1'b0, 3);
    stream(16, 0, 1'b0, 1'b0, -1);
    chk("m_done_now", int'(done), 1);
    @(posedge clk); #1;
    chk("m_beats", acc_log.size(), 16);
    chk("m_err", int'(err), 1);

    // ks = 0 weight load behaves like bias.
    acc_log.delete();
    do_start(1'b0, 0);
    stream(4, 4, 1'b0, 1'b0, -1);
    @(posedge clk); #1;
    chk("k0_beats", acc_log.size(), 4);
    if (acc_log.size() >= 4) chk("k0_beat4", acc_log[3], 3 * 1024);
    chk("k0_err", int'(err), 0);

    // Abort after five beats, then a fresh load starts from 0/0.
    d0 = done_cnt;
    do_start(1'b0, 3);
    stream(16, 0, 1'b0, 1'b0, 5);
    repeat (3) @(posedge clk);
    #1;
    chk("a_no_done", done_cnt - d0, 0);
    full_weight_ks3();

    // start and abort together stay idle.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("sa_idle", int'(busy), 0);

    // Asynchronous reset in the middle of a load.
    do_start(1'b0, 3);
    stream(5, 0, 1'b0, 1'b0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_ready", int'(sif.src_ready), 0);
    chk("ar_va", int'(prm_v) * 1024 + int'(prm_a), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_err", int'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    full_weight_ks3();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
